spd_window_monitor: RTL and testbench
=====================================

// Module: spd_window_monitor
// PURPOSE
//  Synthesizable N-channel motor-speed monitor for the Segway datapath; samples lft_spd/rght_spd-class signals
//  from the balance controller. After a settle delay it averages each channel over a 2^LOG2_WIN-sample window,
//  checks the new average against the previous window in an expected direction, and checks all channels
//  against channel 0 within a tolerance. Serves as on-chip self-check and as a bench-reusable checker.
// PARAMETERS
//  NUM_CH     2     number of speed channels (>=1)
//  W          16    signed width of each speed sample
//  LOG2_WIN   10    window length = 2**LOG2_WIN samples (1..16)
//  SETTLE     1024  cycles spent in SETTLE before sampling (>=1)
//  MATCH_TOL  10    max allowed |spd[i]-spd[0]|, unsigned, < 2**(W-1)
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous, active-high reset
//  start         in   1          pulse: begin a measurement (honoured only in IDLE)
//  exp_dir       in   2          expected change vs previous window: 00 skip, 01 increase, 10 decrease, 11 skip
//  abort         in   1          return to IDLE; window discarded
//  smpl_vld      in   1          spd valid this cycle
//  spd           in   NUM_CH*W   packed signed samples, channel i at [i*W +: W]
//  clr_err       in   1          clears dir_err, match_err, mismatch_cnt
//  busy          out  1          state != IDLE
//  avg_vld       out  1          one-cycle pulse: avg updated
//  avg           out  NUM_CH*W   packed signed window averages (held until next avg_vld)
//  dir_err       out  NUM_CH     sticky per-channel direction failure
//  match_err     out  1          sticky channel-mismatch flag
//  mismatch_cnt  out  16         saturating count of mismatching samples
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; prev_vld=0; accumulators and counters 0.
//  FSM IDLE -> SETTLE on start (latch exp_dir, clear settle counter).
//      SETTLE: count clk cycles; after SETTLE cycles -> ACCUM (clear sums and sample count).
//      ACCUM: on smpl_vld add each sign-extended sample to a W+LOG2_WIN-bit sum; on the 2**LOG2_WIN-th
//             accepted sample -> DONE. Cycles without smpl_vld are not counted.
//      DONE (1 cycle): avg[i] = sum[i] >>> LOG2_WIN (arithmetic, rounds toward -inf), truncated to W bits;
//             avg_vld=1; direction check; prev_avg <= avg; prev_vld <= 1; -> IDLE.
//  Latency: avg_vld asserts exactly 1 cycle after the cycle accepting the last sample.
//  Direction check, only in DONE with prev_vld=1 and exp_dir in {01,10}: 01 needs new>prev strictly,
//      10 needs new<prev strictly; equality fails. On failure set dir_err[i]. First window after reset: no check.
//  Match check: any cycle with state in {SETTLE,ACCUM} and smpl_vld, for i>=1: if |spd[i]-spd[0]| > MATCH_TOL
//      (computed at W+1 bits, no overflow) then match_err<=1 and mismatch_cnt += 1 (one per cycle, not per
//      channel), saturating at 16'hFFFF.
//  start outside IDLE: ignored. abort: any state -> IDLE next cycle, no avg_vld, prev_avg/prev_vld untouched;
//      abort wins over start in the same cycle.
//  clr_err with a same-cycle error event: the set wins (flag=1, cnt=1).
//  rst mid-operation: immediate return to reset values including prev_vld=0.
// STRUCTURE
//  Package spd_mon_pkg: state enum (IDLE,SETTLE,ACCUM,DONE); dir encodings DIR_SKIP/DIR_INC/DIR_DEC.
//  Sub-module spd_win_accum (one channel: sum register, avg compute, prev_avg, direction compare),
//  instantiated NUM_CH times by generate; top holds FSM, counters, match checker and packing.
// TESTING (NUM_CH=2, W=16, LOG2_WIN=2, SETTLE=4, MATCH_TOL=10)
//  1 Assert rst mid-run -> all outputs 0 asynchronously; busy=0; next window does no direction check.
//  2 start, smpl_vld=1, spd={100,100} -> busy for 1+4+4 cycles, avg_vld 1 cycle after 4th sample,
//    avg={100,100}, no errors.
//  3 Samples ch0 -1,-2,-2,-2 -> avg[0]=-2 (sum -7 >>> 2); ch0 7,7,7,6 -> avg=6.
//  4 Window at 100, then exp_dir=01 with 150 -> dir_err=0; again exp_dir=01 with 150 -> dir_err=2'b11;
//    clr_err -> 0; exp_dir=10 with 120 -> no error.
//  5 spd={111,100} during SETTLE+ACCUM (8 valid cycles) -> match_err=1, mismatch_cnt=8;
//    spd={110,100} -> no error; {-32768,32767} -> mismatch detected without overflow.
//  6 abort in ACCUM -> IDLE, no avg_vld, avg/prev unchanged; start while busy is ignored.

Source files
------------

// File: rtl/spd_mon_pkg.sv
// Shared types for the speed-window monitor: FSM states and expected-direction codes.
package spd_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] DIR_SKIP = 2'b00;
    localparam logic [1:0] DIR_INC  = 2'b01;
    localparam logic [1:0] DIR_DEC  = 2'b10;

endpackage

// File: rtl/spd_win_accum.sv
// One speed channel: window sum, average, previous-window average and direction check.
module spd_win_accum
    import spd_mon_pkg::*;
#(
    parameter int W        = 16,
    parameter int LOG2_WIN = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                add,
    input  logic                load_avg,
    input  logic                done,
    input  logic                prev_vld,
    input  logic [1:0]          dir,
    input  logic                clr_err,
    input  logic signed [W-1:0] sample,
    output logic signed [W-1:0] avg,
    output logic                dir_err
);
    localparam int SUM_W = W + LOG2_WIN;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_nxt;
    logic signed [SUM_W-1:0] sum_shr;
    logic signed [W-1:0]     prev_avg;
    logic                    fail;

    assign sum_nxt = sum + {{LOG2_WIN{sample[W-1]}}, sample};
    // The window mean of W-bit samples always fits back into W bits.
    assign sum_shr = sum_nxt >>> LOG2_WIN;

    always_comb begin
        fail = 1'b0;
        if (done && prev_vld) begin
            if (dir == DIR_INC && !(avg > prev_avg)) fail = 1'b1;
            if (dir == DIR_DEC && !(avg < prev_avg)) fail = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            avg      <= '0;
            prev_avg <= '0;
            dir_err  <= 1'b0;
        end else begin
            if (clr)
                sum <= '0;
            else if (add)
                sum <= sum_nxt;
            if (load_avg)
                avg <= sum_shr[W-1:0];
            if (done)
                prev_avg <= avg;
            if (fail)
                dir_err <= 1'b1;
            else if (clr_err)
                dir_err <= 1'b0;
        end
    end

endmodule

// File: rtl/spd_window_monitor.sv
// N-channel speed monitor: settle, window-average, direction check vs previous window,
// and cross-channel match check against channel 0.
module spd_window_monitor
    import spd_mon_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int W         = 16,
    parameter int LOG2_WIN  = 10,
    parameter int SETTLE    = 1024,
    parameter int MATCH_TOL = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            exp_dir,
    input  logic                  abort,
    input  logic                  smpl_vld,
    input  logic [NUM_CH*W-1:0]   spd,
    input  logic                  clr_err,
    output logic                  busy,
    output logic                  avg_vld,
    output logic [NUM_CH*W-1:0]   avg,
    output logic [NUM_CH-1:0]     dir_err,
    output logic                  match_err,
    output logic [15:0]           mismatch_cnt
);
    localparam int SCW = $clog2(SETTLE + 1);

    state_t              state, state_nxt;
    logic [SCW-1:0]      settle_cnt;
    logic [LOG2_WIN-1:0] samp_cnt;
    logic [1:0]          dir_lat;
    logic                prev_vld;
    logic                settle_last, samp_last;
    logic                take, last, sum_clr, done_ok, checking, any_mis;
    logic [NUM_CH-1:0]   mis;

    assign settle_last = (settle_cnt == SCW'(SETTLE - 1));
    assign samp_last   = &samp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_SETTLE;
                ST_SETTLE: if (settle_last) state_nxt = ST_ACCUM;
                ST_ACCUM:  if (smpl_vld && samp_last) state_nxt = ST_DONE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        avg_vld  = (state == ST_DONE);
        take     = (state == ST_ACCUM) && smpl_vld && !abort;
        last     = take && samp_last;
        sum_clr  = (state == ST_SETTLE) && settle_last;
        done_ok  = (state == ST_DONE) && !abort;
        checking = ((state == ST_SETTLE) || (state == ST_ACCUM)) && smpl_vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            dir_lat    <= DIR_SKIP;
            prev_vld   <= 1'b0;
        end else begin
            if (state == ST_IDLE)
                settle_cnt <= '0;
            else if (state == ST_SETTLE)
                settle_cnt <= settle_cnt + 1'b1;
            if (state != ST_ACCUM)
                samp_cnt <= '0;
            else if (take)
                samp_cnt <= samp_cnt + 1'b1;
            if (state == ST_IDLE && start && !abort)
                dir_lat <= exp_dir;
            if (done_ok)
                prev_vld <= 1'b1;
        end
    end

    // Differences taken one bit wider than the samples so extreme pairs cannot wrap.
    assign mis[0] = 1'b0;
    for (genvar i = 1; i < NUM_CH; i++) begin : g_match
        logic signed [W:0] diff;
        logic        [W:0] mag;
        assign diff   = $signed({spd[i*W+W-1], spd[i*W +: W]}) - $signed({spd[W-1], spd[W-1:0]});
        assign mag    = diff[W] ? -diff : diff;
        assign mis[i] = (mag > (W+1)'(MATCH_TOL));
    end

    assign any_mis = checking && (|mis);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_err    <= 1'b0;
            mismatch_cnt <= '0;
        end else if (any_mis) begin
            match_err <= 1'b1;
            if (clr_err)
                mismatch_cnt <= 16'd1;
            else if (mismatch_cnt != 16'hFFFF)
                mismatch_cnt <= mismatch_cnt + 16'd1;
        end else if (clr_err) begin
            match_err    <= 1'b0;
            mismatch_cnt <= '0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spd_win_accum #(
            .W        (W),
            .LOG2_WIN (LOG2_WIN)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .clr      (sum_clr),
            .add      (take),
            .load_avg (last),
            .done     (done_ok),
            .prev_vld (prev_vld),
            .dir      (dir_lat),
            .clr_err  (clr_err),
            .sample   (spd[i*W +: W]),
            .avg      (avg[i*W +: W]),
            .dir_err  (dir_err[i])
        );
    end

endmodule

// File: tb/tb_spd_window_monitor.sv
// Bench for spd_window_monitor: transaction-level model checked every cycle, plus directed literals.
module tb_spd_window_monitor;
    localparam int NUM_CH = 2, W = 16, LOG2_WIN = 2, SETTLE = 4, MATCH_TOL = 10;
    localparam int WIN = 1 << LOG2_WIN;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, smpl_vld = 1'b0, clr_err = 1'b0;
    logic [1:0] exp_dir = 2'b00;
    logic [NUM_CH*W-1:0] spd = '0;
    logic busy, avg_vld, match_err;
    logic [NUM_CH*W-1:0] avg;
    logic [NUM_CH-1:0] dir_err;
    logic [15:0] mismatch_cnt;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    spd_window_monitor #(
        .NUM_CH(NUM_CH), .W(W), .LOG2_WIN(LOG2_WIN), .SETTLE(SETTLE), .MATCH_TOL(MATCH_TOL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .exp_dir(exp_dir), .abort(abort),
        .smpl_vld(smpl_vld), .spd(spd), .clr_err(clr_err), .busy(busy), .avg_vld(avg_vld),
        .avg(avg), .dir_err(dir_err), .match_err(match_err), .mismatch_cnt(mismatch_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int ch(input logic [NUM_CH*W-1:0] v, input int i);
        logic signed [W-1:0] s;
        s = v[i*W +: W];
        return int'(s);
    endfunction

    function automatic int floor_div(input int a);
        int q;
        q = a / WIN;
        if ((a % WIN) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Model: a window is "active" for SETTLE cycles, then collects WIN valid samples, then one result cycle.
    bit m_active, m_pulse, m_prev_vld, m_match, m_mis;
    int m_settle_left, m_cnt, m_mcnt, m_d;
    bit [1:0] m_dir;
    int m_sum[NUM_CH], m_avg[NUM_CH], m_prev[NUM_CH];
    bit [NUM_CH-1:0] m_derr, m_fail;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_pulse = 0; m_prev_vld = 0; m_match = 0; m_mcnt = 0; m_cnt = 0;
            m_settle_left = 0; m_dir = 0; m_derr = '0;
            for (int i = 0; i < NUM_CH; i++) begin m_sum[i] = 0; m_avg[i] = 0; m_prev[i] = 0; end
        end else begin
            m_mis = 0;
            if (m_active && !m_pulse && smpl_vld)
                for (int i = 1; i < NUM_CH; i++) begin
                    m_d = ch(spd, i) - ch(spd, 0);
                    if (m_d < 0) m_d = -m_d;
                    if (m_d > MATCH_TOL) m_mis = 1;
                end
            if (m_mis) begin
                m_match = 1;
                m_mcnt = clr_err ? 1 : (m_mcnt < 65535 ? m_mcnt + 1 : 65535);
            end else if (clr_err) begin
                m_match = 0; m_mcnt = 0;
            end
            m_fail = '0;
            if (m_pulse && !abort && m_prev_vld)
                for (int i = 0; i < NUM_CH; i++)
                    if ((m_dir == 2'b01 && !(m_avg[i] > m_prev[i])) ||
                        (m_dir == 2'b10 && !(m_avg[i] < m_prev[i]))) m_fail[i] = 1;
            m_derr = (clr_err ? '0 : m_derr) | m_fail;
            if (m_pulse && !abort) begin
                m_prev = m_avg; m_prev_vld = 1;
            end
            if (abort) begin
                m_active = 0; m_pulse = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1; m_settle_left = SETTLE; m_dir = exp_dir; m_cnt = 0;
                    for (int i = 0; i < NUM_CH; i++) m_sum[i] = 0;
                end
            end else if (m_pulse) begin
                m_active = 0; m_pulse = 0;
            end else if (m_settle_left > 0) begin
                m_settle_left--;
            end else if (smpl_vld) begin
                for (int i = 0; i < NUM_CH; i++) m_sum[i] += ch(spd, i);
                m_cnt++;
                if (m_cnt == WIN) begin
                    for (int i = 0; i < NUM_CH; i++) m_avg[i] = floor_div(m_sum[i]);
                    m_pulse = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH*W-1:0] exp_avg;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) exp_avg[i*W +: W] = 16'(m_avg[i]);
            chk("busy", busy, m_active);
            chk("avg_vld", avg_vld, m_pulse);
            chk("avg", avg, exp_avg);
            chk("dir_err", dir_err, m_derr);
            chk("match_err", match_err, m_match);
            chk("mismatch_cnt", mismatch_cnt, 16'(m_mcnt));
        end
    end

    int w0[WIN], w1[WIN];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int c1, input int c0);
        spd = {16'(c1), 16'(c0)};
    endtask

    task automatic fill(input int c1, input int c0);
        for (int k = 0; k < WIN; k++) begin w1[k] = c1; w0[k] = c0; end
    endtask

    task automatic run_win(input logic [1:0] d, input bit vld_settle);
        exp_dir = d; start = 1; smpl_vld = vld_settle; put(w1[0], w0[0]);
        tick;
        start = 0;
        repeat (SETTLE) tick;
        for (int k = 0; k < WIN; k++) begin
            put(w1[k], w0[k]); smpl_vld = 1;
            tick;
        end
        chk("win_avg_vld", avg_vld, 1'b1);
        smpl_vld = 0;
        tick;
    endtask

    initial begin
        int n, vat, base;
        tick; tick;
        chk("rst_busy", busy, 1'b0);
        chk("rst_avg", avg, 32'h0);
        chk("rst_cnt", mismatch_cnt, 16'h0);
        rst = 0;
        tick;

        // Steady 100 on both channels: 1 start + 4 settle + 4 accum + 1 done.
        put(100, 100); smpl_vld = 1; start = 1;
        tick;
        start = 0; n = 0; vat = -1;
        while (busy && n < 50) begin
            if (avg_vld) vat = n;
            n++;
            tick;
        end
        chk("busy_cycles", n, 9);
        chk("avg_vld_at", vat, 8);
        chk("avg_100", avg, {16'd100, 16'd100});
        chk("no_match_err", match_err, 1'b0);
        smpl_vld = 0;

        // Floor rounding: -7>>>2 = -2, 27>>>2 = 6.
        w0 = '{-1, -2, -2, -2}; w1 = '{7, 7, 7, 6};
        run_win(2'b00, 0);
        chk("avg0_floor", avg[15:0], 16'hFFFE);
        chk("avg1_floor", avg[31:16], 16'd6);

        fill(100, 100); run_win(2'b00, 0);
        fill(150, 150); run_win(2'b01, 0);
        chk("dir_inc_ok", dir_err, 2'b00);
        run_win(2'b01, 0);
        chk("dir_inc_eq", dir_err, 2'b11);
        clr_err = 1; tick; clr_err = 0;
        chk("dir_clr", dir_err, 2'b00);
        fill(120, 120); run_win(2'b10, 0);
        chk("dir_dec_ok", dir_err, 2'b00);

        fill(111, 100); run_win(2'b00, 1);
        chk("mis_flag", match_err, 1'b1);
        chk("mis_cnt8", mismatch_cnt, 16'd8);
        clr_err = 1; tick; clr_err = 0;
        fill(110, 100); run_win(2'b00, 1);
        chk("tol_edge_cnt", mismatch_cnt, 16'd0);
        fill(-32768, 32767); run_win(2'b00, 0);
        chk("extreme_cnt", mismatch_cnt, 16'd4);
        chk("extreme_flag", match_err, 1'b1);

        // clr_err coinciding with a mismatch: the new event survives.
        exp_dir = 0; start = 1; smpl_vld = 0; tick; start = 0;
        put(111, 100); smpl_vld = 1; clr_err = 1; tick; clr_err = 0;
        chk("clr_vs_set", mismatch_cnt, 16'd1);
        abort = 1; smpl_vld = 0; tick; abort = 0;
        chk("abort_settle", busy, 1'b0);
        clr_err = 1; tick; clr_err = 0;

        // Abort mid-accumulation leaves avg and previous window untouched.
        fill(50, 50); run_win(2'b00, 0);
        start = 1; tick; start = 0;
        repeat (SETTLE) tick;
        put(200, 200); smpl_vld = 1; tick; tick;
        abort = 1; tick; abort = 0; smpl_vld = 0;
        chk("abort_idle", busy, 1'b0);
        chk("abort_avg", avg, {16'd50, 16'd50});
        tick;
        // A second start while busy must not relatch exp_dir or restart settle.
        exp_dir = 2'b01; start = 1; tick;
        exp_dir = 2'b00; start = 1; tick; start = 0;
        repeat (SETTLE - 1) tick;
        for (int k = 0; k < WIN; k++) begin put(40, 40); smpl_vld = 1; tick; end
        chk("restart_ignored", avg_vld, 1'b1);
        smpl_vld = 0; tick;
        chk("prev_kept", dir_err, 2'b11);
        clr_err = 1; tick; clr_err = 0;

        // Reset mid-window: outputs clear at once, next window skips the direction check.
        fill(10, 10);
        start = 1; put(111, 100); smpl_vld = 1; tick; start = 0;
        tick; tick;
        #1 rst = 1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_avg", avg, 32'h0);
        chk("arst_match", match_err, 1'b0);
        chk("arst_cnt", mismatch_cnt, 16'h0);
        smpl_vld = 0;
        tick; rst = 0; tick;
        run_win(2'b01, 0);
        chk("post_rst_nocheck", dir_err, 2'b00);
        chk("post_rst_avg", avg, {16'd10, 16'd10});

        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom % 6) == 0;
            abort    = ($urandom % 60) == 0;
            smpl_vld = ($urandom % 4) != 0;
            clr_err  = ($urandom % 40) == 0;
            exp_dir  = 2'($urandom);
            if (($urandom % 20) == 0) begin
                spd = {16'($urandom), 16'($urandom)};
            end else begin
                base = int'($urandom_range(0, 400)) - 200;
                put(base + int'($urandom_range(0, 24)) - 12, base);
            end
            tick;
        end
        start = 0; abort = 0; smpl_vld = 0; clr_err = 0;
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
